// File: rtl/lshift_ctrl.sv
// Sequencer for a parameterised left-shift register: accepts one load/shift
// operation per handshake, strobes the register, and returns data plus spilled bits.
module lshift_ctrl #(
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [WIDTH-1:0] op_data,
    input  logic [AW-1:0]    op_amt,
    input  logic             op_fill,
    output logic             reg_load,
    output logic             reg_shift,
    output logic [WIDTH-1:0] reg_din,
    output logic             reg_sh_in,
    input  logic [WIDTH-1:0] reg_q,
    input  logic             reg_sh_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic [WIDTH-1:0] res_spill,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [AW-1:0] AMT_MAX = AW'(WIDTH);
    localparam logic [AW-1:0] AMT_ONE = AW'(1);

    state_t          state_r;
    logic [AW-1:0]   amt_r;
    logic [AW-1:0]   cnt_r;
    logic [AW-1:0]   amt_sat_s;
    logic [WIDTH-1:0] final_q_s;

    // Saturate the requested amount so the counter never exceeds WIDTH shifts.
    always_comb begin
        amt_sat_s = op_amt;
        if (op_amt > AMT_MAX) begin
            amt_sat_s = AMT_MAX;
        end else begin
            amt_sat_s = op_amt;
        end
    end

    // Register contents that the final shift edge settles to.
    always_comb begin
        final_q_s = {reg_q[WIDTH-2:0], reg_sh_in};
    end

    // Operation sequencer with registered strobes and result outputs.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_r   <= ST_IDLE;
            amt_r     <= {AW{1'b0}};
            cnt_r     <= {AW{1'b0}};
            op_ready  <= 1'b1;
            reg_load  <= 1'b0;
            reg_shift <= 1'b0;
            reg_din   <= {WIDTH{1'b0}};
            reg_sh_in <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= {WIDTH{1'b0}};
            res_spill <= {WIDTH{1'b0}};
            busy      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (op_valid) begin
                        state_r   <= ST_LOAD;
                        reg_din   <= op_data;
                        reg_sh_in <= op_fill;
                        amt_r     <= amt_sat_s;
                        res_spill <= {WIDTH{1'b0}};
                        op_ready  <= 1'b0;
                        busy      <= 1'b1;
                        reg_load  <= 1'b1;
                    end else begin
                        state_r   <= ST_IDLE;
                        op_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    reg_load <= 1'b0;
                    if (amt_r == {AW{1'b0}}) begin
                        // Nothing to shift: the register simply holds the loaded value.
                        state_r   <= ST_DONE;
                        res_data  <= reg_din;
                        res_valid <= 1'b1;
                    end else begin
                        state_r   <= ST_SHIFT;
                        cnt_r     <= amt_r;
                        reg_shift <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    res_spill <= {res_spill[WIDTH-2:0], reg_sh_out};
                    cnt_r     <= cnt_r - AMT_ONE;
                    if (cnt_r == AMT_ONE) begin
                        state_r   <= ST_DONE;
                        reg_shift <= 1'b0;
                        res_valid <= 1'b1;
                        res_data  <= final_q_s;
                    end else begin
                        state_r   <= ST_SHIFT;
                        reg_shift <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        state_r   <= ST_IDLE;
                        res_valid <= 1'b0;
                        op_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        state_r   <= ST_DONE;
                        res_valid <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    op_ready  <= 1'b1;
                    reg_load  <= 1'b0;
                    reg_shift <= 1'b0;
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lshift_ctrl.sv
// Scoreboard bench for lshift_ctrl: a behavioural shift register closes the loop,
// directed operations push expected results, a negedge monitor checks them.
module tb_lshift_ctrl;

    localparam int W  = 8;
    localparam int AW = 4;

    logic          clk;
    logic          rst_b;
    logic          op_valid;
    logic          op_ready;
    logic [W-1:0]  op_data;
    logic [AW-1:0] op_amt;
    logic          op_fill;
    logic          reg_load;
    logic          reg_shift;
    logic [W-1:0]  reg_din;
    logic          reg_sh_in;
    logic [W-1:0]  reg_q;
    logic          reg_sh_out;
    logic          res_valid;
    logic          res_ready;
    logic [W-1:0]  res_data;
    logic [W-1:0]  res_spill;
    logic          busy;

    lshift_ctrl #(.WIDTH(W), .AW(AW)) dut (
        .clk(clk), .rst_b(rst_b),
        .op_valid(op_valid), .op_ready(op_ready), .op_data(op_data),
        .op_amt(op_amt), .op_fill(op_fill),
        .reg_load(reg_load), .reg_shift(reg_shift), .reg_din(reg_din),
        .reg_sh_in(reg_sh_in), .reg_q(reg_q), .reg_sh_out(reg_sh_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_spill(res_spill), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model of the controlled shift register.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b)         reg_q <= '0;
        else if (reg_load)  reg_q <= reg_din;
        else if (reg_shift) reg_q <= {reg_q[W-2:0], reg_sh_in};
    end
    assign reg_sh_out = reg_q[W-1];

    typedef struct {
        logic [W-1:0] d;
        logic [W-1:0] s;
        int           amt;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   t_acc    = 0;
    bit   active   = 1'b0;
    bit   first_v  = 1'b1;
    logic [W-1:0] snap_d;
    logic [W-1:0] snap_s;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: models handshake state and pops the scoreboard at each accept.
    initial forever begin
        @(negedge clk);
        if (!rst_b) begin
            active  = 1'b0;
            first_v = 1'b1;
        end else begin
            chk("op_ready", 32'(op_ready), 32'(!active));
            chk("busy", 32'(busy), 32'(active));
            chk("load_shift_overlap", 32'(reg_load && reg_shift), 32'd0);
            if (active) begin
                chk("reg_load_timing", 32'(reg_load), 32'(cyc == t_acc));
                chk("reg_shift_timing", 32'(reg_shift),
                    32'((cyc >= t_acc + 1) && (cyc <= t_acc + cur.amt)));
                chk("res_valid_timing", 32'(res_valid), 32'(cyc >= t_acc + 1 + cur.amt));
                if (res_valid) begin
                    if (first_v) begin
                        snap_d  = res_data;
                        snap_s  = res_spill;
                        first_v = 1'b0;
                    end else begin
                        chk("res_data_stable", 32'(res_data), 32'(snap_d));
                        chk("res_spill_stable", 32'(res_spill), 32'(snap_s));
                    end
                    if (res_ready) begin
                        chk("res_data", 32'(res_data), 32'(cur.d));
                        chk("res_spill", 32'(res_spill), 32'(cur.s));
                        active = 1'b0;
                    end
                end
            end else begin
                chk("idle_res_valid", 32'(res_valid), 32'd0);
                chk("idle_strobes", 32'({reg_load, reg_shift}), 32'd0);
                if (op_valid && op_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL scoreboard: unexpected accept, got 1 expected 0");
                    end else begin
                        cur = exp_q.pop_front();
                    end
                    t_acc   = cyc + 1;
                    active  = 1'b1;
                    first_v = 1'b1;
                end
            end
        end
    end

    task automatic wait_accept();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!op_ready && n < 60);
        if (!op_ready) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        op_valid = 1'b0;
    endtask

    task automatic issue(input logic [W-1:0] d, input logic [AW-1:0] a, input logic f,
                         input logic [W-1:0] ed, input logic [W-1:0] es, input int eamt);
        exp_q.push_back('{d: ed, s: es, amt: eamt});
        op_data  = d;
        op_amt   = a;
        op_fill  = f;
        op_valid = 1'b1;
        wait_accept();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((active || exp_q.size() != 0) && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (active || exp_q.size() != 0) chk("result_timeout", 32'd0, 32'd1);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_op_ready"}, 32'(op_ready), 32'd1);
        chk({tag, "_strobes"}, 32'({reg_load, reg_shift, reg_sh_in}), 32'd0);
        chk({tag, "_reg_din"}, 32'(reg_din), 32'd0);
        chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        chk({tag, "_res_data"}, 32'(res_data), 32'd0);
        chk({tag, "_res_spill"}, 32'(res_spill), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        rst_b     = 1'b0;
        op_valid  = 1'b0;
        op_data   = '0;
        op_amt    = '0;
        op_fill   = 1'b0;
        res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_values("reset");
        rst_b = 1'b1;
        @(posedge clk);
        #1;

        // Basic, zero, full and saturated shifts.
        issue(8'h55, 4'd3, 1'b1, 8'hAF, 8'h02, 3);
        wait_idle();
        issue(8'hAA, 4'd0, 1'b0, 8'hAA, 8'h00, 0);
        wait_idle();
        issue(8'hC3, 4'd8, 1'b0, 8'h00, 8'hC3, 8);
        wait_idle();
        issue(8'hC3, 4'd15, 1'b0, 8'h00, 8'hC3, 8);
        wait_idle();

        // Back-pressure with a competing request held during DONE.
        res_ready = 1'b0;
        issue(8'hF0, 4'd4, 1'b0, 8'h00, 8'h0F, 4);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!res_valid && n < 40);
        chk("bp_res_valid_seen", 32'(res_valid), 32'd1);
        @(posedge clk);
        #1;
        exp_q.push_back('{d: 8'h07, s: 8'h02, amt: 2});
        op_data  = 8'h81;
        op_amt   = 4'd2;
        op_fill  = 1'b1;
        op_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("bp_op_ready_low", 32'(op_ready), 32'd0);
        res_ready = 1'b1;
        wait_accept();
        wait_idle();

        // Reset during the second shift cycle of an amt=6 operation.
        issue(8'hC3, 4'd6, 1'b1, 8'h00, 8'h00, 6);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("pre_reset_shift", 32'(reg_shift), 32'd1);
        #1;
        rst_b = 1'b0;
        #1;
        chk_reset_values("midreset");
        repeat (2) @(posedge clk);
        #1;
        chk_reset_values("midreset_hold");
        rst_b = 1'b1;
        @(posedge clk);
        #1;
        issue(8'h55, 4'd1, 1'b0, 8'hAA, 8'h00, 1);
        wait_idle();

        // Inputs change right after accept; results must use latched values.
        issue(8'h3C, 4'd2, 1'b1, 8'hF3, 8'h00, 2);
        op_data = 8'hFF;
        op_amt  = 4'd7;
        op_fill = 1'b0;
        wait_idle();
        issue(8'h96, 4'd5, 1'b0, 8'hC0, 8'h12, 5);
        op_data = 8'h00;
        op_amt  = 4'd15;
        op_fill = 1'b1;
        wait_idle();

        repeat (3) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
